// File: rtl/step_move_ctrl_if.sv
// Command/status bundle between a move requester (master) and step_move_ctrl (slave).
// With STEP_POS_TRACK_EN defined the bundle also carries the absolute position `pos`.
interface step_move_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             start;
  logic             dir_in;
  logic [CNT_W-1:0] steps;
  logic             abort;
  logic             busy;
  logic             done;
  logic             step_out;
  logic             dir;
  logic [CNT_W-1:0] steps_left;
`ifdef STEP_POS_TRACK_EN
  logic [CNT_W-1:0] pos;

  modport master (
    output start, dir_in, steps, abort,
    input  busy, done, step_out, dir, steps_left, pos
  );
  modport slave (
    input  start, dir_in, steps, abort,
    output busy, done, step_out, dir, steps_left, pos
  );
`else
  modport master (
    output start, dir_in, steps, abort,
    input  busy, done, step_out, dir, steps_left
  );
  modport slave (
    input  start, dir_in, steps, abort,
    output busy, done, step_out, dir, steps_left
  );
`endif
endinterface

// File: rtl/step_move_ctrl.sv
// Trapezoidal step/dir move generator: ramps half-period START_HALF -> MIN_HALF, cruises, ramps back.
// Optional STEP_POS_TRACK_EN adds a wrapping signed absolute position output (bus.pos).
module step_move_ctrl #(
  parameter int CNT_W      = 32,
  parameter int PER_W      = 20,
  parameter int START_HALF = 25000,
  parameter int MIN_HALF   = 3676,
  parameter int ACCEL_STEP = 50
) (
  input logic          clk,
  input logic          rst,
  step_move_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, FIN} state_t;

  localparam logic [PER_W-1:0] START_P    = PER_W'(START_HALF);
  localparam logic [PER_W-1:0] MIN_P      = PER_W'(MIN_HALF);
  localparam logic [PER_W-1:0] STEP_P     = PER_W'(ACCEL_STEP);
  localparam logic [PER_W:0]   START_X    = (PER_W+1)'(START_HALF);
  localparam logic [PER_W:0]   STEP_X     = (PER_W+1)'(ACCEL_STEP);
  localparam logic [PER_W:0]   MIN_STEP_X = (PER_W+1)'(MIN_HALF + ACCEL_STEP);

  state_t           state_reg;
  logic [PER_W-1:0] half_reg;
  logic [PER_W-1:0] phase_cnt_reg;
  logic [CNT_W-1:0] steps_left_reg;
  logic [CNT_W-1:0] ramp_cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             step_out_reg;
  logic             dir_reg;
  logic             abort_pend_reg;
`ifdef STEP_POS_TRACK_EN
  logic [CNT_W-1:0] pos_reg;
`endif

  logic [PER_W:0]   half_up;
  logic [PER_W-1:0] half_up_sat;
  logic             near_min;
  logic             phase_end;
  logic             abort_now;
  logic [CNT_W-1:0] left_dec;
  logic [CNT_W-1:0] left_next;

  // Widened by one bit so the down-ramp increment cannot wrap before saturating.
  assign half_up     = {1'b0, half_reg} + STEP_X;
  assign half_up_sat = (half_up > START_X) ? START_P : half_up[PER_W-1:0];
  assign near_min    = ({1'b0, half_reg} <= MIN_STEP_X);
  assign phase_end   = (phase_cnt_reg == half_reg - 1'b1);
  assign abort_now   = abort_pend_reg | bus.abort;
  assign left_dec    = steps_left_reg - 1'b1;
  // An abort shortens the move so that only the mirrored down-ramp remains.
  assign left_next   = (abort_now && (ramp_cnt_reg < left_dec)) ? ramp_cnt_reg : left_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      step_out_reg   <= 1'b0;
      dir_reg        <= 1'b0;
      steps_left_reg <= '0;
      half_reg       <= START_P;
      ramp_cnt_reg   <= '0;
      phase_cnt_reg  <= '0;
      abort_pend_reg <= 1'b0;
`ifdef STEP_POS_TRACK_EN
      pos_reg        <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            dir_reg        <= bus.dir_in;
            half_reg       <= START_P;
            ramp_cnt_reg   <= '0;
            phase_cnt_reg  <= '0;
            step_out_reg   <= 1'b0;
            abort_pend_reg <= 1'b0;
            if (bus.steps != '0) begin
              steps_left_reg <= bus.steps;
              busy_reg       <= 1'b1;
              state_reg      <= ACCEL;
            end else begin
              state_reg <= FIN;
            end
          end
        end
        ACCEL, CRUISE, DECEL: begin
          if (bus.abort) abort_pend_reg <= 1'b1;
          if (!phase_end) begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end else begin
            phase_cnt_reg <= '0;
            step_out_reg  <= ~step_out_reg;
            if (step_out_reg) begin
              steps_left_reg <= left_next;
              abort_pend_reg <= 1'b0;
`ifdef STEP_POS_TRACK_EN
              pos_reg <= dir_reg ? pos_reg + 1'b1 : pos_reg - 1'b1;
`endif
              if (left_next == '0) begin
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= FIN;
              end else if (state_reg == DECEL) begin
                half_reg <= half_up_sat;
              end else if (left_next <= ramp_cnt_reg) begin
                half_reg  <= half_up_sat;
                state_reg <= DECEL;
              end else if (state_reg == ACCEL) begin
                ramp_cnt_reg <= ramp_cnt_reg + 1'b1;
                if (near_min) begin
                  half_reg  <= MIN_P;
                  state_reg <= CRUISE;
                end else begin
                  half_reg <= half_reg - STEP_P;
                end
              end
            end
          end
        end
        FIN: begin
          // A zero-step move arrives here with done low and raises it one cycle later.
          busy_reg       <= 1'b0;
          step_out_reg   <= 1'b0;
          abort_pend_reg <= 1'b0;
          if (done_reg) begin
            done_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.step_out   = step_out_reg;
  assign bus.dir        = dir_reg;
  assign bus.steps_left = steps_left_reg;
`ifdef STEP_POS_TRACK_EN
  assign bus.pos        = pos_reg;
`endif
endmodule

// File: tb/tb_step_move_ctrl.sv
// Randomized self-checking bench for step_move_ctrl against a step-level profile model.
// Honours STEP_POS_TRACK_EN when defined (position checks).
module tb_step_move_ctrl;
  localparam int CNT_W      = 16;
  localparam int PER_W      = 20;
  localparam int START_HALF = 10;
  localparam int MIN_HALF   = 4;
  localparam int ACCEL_STEP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  step_move_ctrl_if #(.CNT_W(CNT_W)) bus ();

  step_move_ctrl #(
    .CNT_W(CNT_W), .PER_W(PER_W), .START_HALF(START_HALF),
    .MIN_HALF(MIN_HALF), .ACCEL_STEP(ACCEL_STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_h[$];
  int pos_model = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Half-period of every step of a move, from the ramp/cruise/abort rules.
  function automatic void build_model(input int n, input int abort_at);
    int half, ramp, left, k;
    bit cruising, falling;
    exp_h.delete();
    half = START_HALF; ramp = 0; left = n; k = 0;
    cruising = 0; falling = 0;
    while (left > 0) begin
      k++;
      exp_h.push_back(half);
      left--;
      if (abort_at == k && ramp < left) left = ramp;
      if (left == 0) break;
      if (falling || left <= ramp) begin
        falling = 1;
        half = (half + ACCEL_STEP > START_HALF) ? START_HALF : half + ACCEL_STEP;
      end else if (!cruising) begin
        ramp++;
        if (half - ACCEL_STEP <= MIN_HALF) begin
          half = MIN_HALF;
          cruising = 1;
        end else begin
          half -= ACCEL_STEP;
        end
      end
    end
  endfunction

  task automatic run_move(input int n, input bit d, input int abort_at, input bit poke);
    int runs[$];
    int c, cur_len, rises, dir_bad, busy_bad, sum, limit, nr;
    bit cur_lvl, aborted, got_done;
    build_model(n, abort_at);
    sum = 0;
    foreach (exp_h[i]) sum += exp_h[i];
    limit = 2 * sum + 20;
    @(negedge clk);
    bus.start = 1'b1; bus.steps = CNT_W'(n); bus.dir_in = d;
    @(negedge clk);
    bus.start = 1'b0; bus.steps = CNT_W'($urandom); bus.dir_in = 1'($urandom);
    if (n != 0) chk("steps_latched", bus.steps_left, 64'(n));
    c = 1; cur_len = 0; cur_lvl = 0; rises = 0; dir_bad = 0; busy_bad = 0;
    aborted = 0; got_done = 0;
    while (c <= limit) begin
      if (bus.done === 1'b1) begin
        got_done = 1;
        break;
      end
      if (bus.busy !== (n != 0)) busy_bad++;
      if (n != 0 && bus.dir !== d) dir_bad++;
      if (bus.step_out !== cur_lvl) begin
        runs.push_back(cur_len);
        if (!cur_lvl) rises++;
        cur_lvl = bus.step_out;
        cur_len = 1;
      end else begin
        cur_len++;
      end
      bus.abort = 1'b0;
      if (abort_at != 0 && !aborted && (runs.size() / 2) == abort_at - 1) begin
        bus.abort = 1'b1;
        aborted = 1;
      end
      bus.start = (poke && c == 3);
      @(negedge clk);
      c++;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    if (cur_lvl) runs.push_back(cur_len);
    chk("done_seen", got_done, 1);
    chk("done_at", c, (n == 0) ? 2 : 2 * sum + 1);
    chk("pulses", rises, exp_h.size());
    chk("run_count", runs.size(), 2 * exp_h.size());
    nr = (runs.size() < 2 * exp_h.size()) ? runs.size() : 2 * exp_h.size();
    for (int i = 0; i < nr; i++)
      chk($sformatf("half[%0d]", i), runs[i], exp_h[i / 2]);
    chk("busy_hold", busy_bad, 0);
    chk("dir_hold", dir_bad, 0);
    chk("busy_at_done", bus.busy, 0);
    chk("step_at_done", bus.step_out, 0);
    chk("left_at_done", bus.steps_left, 0);
    pos_model += d ? exp_h.size() : -exp_h.size();
    if (poke) begin
      bus.start = 1'b1; bus.steps = 7;
      @(negedge clk);
      bus.start = 1'b0;
      chk("fin_start_busy", bus.busy, 0);
      @(negedge clk);
      chk("fin_start_ignored", bus.busy, 0);
    end else begin
      @(negedge clk);
    end
    chk("done_width", bus.done, 0);
`ifdef STEP_POS_TRACK_EN
    chk("pos", bus.pos, 64'(CNT_W'(pos_model)));
`endif
    $display("move n=%0d dir=%0d abort_at=%0d poke=%0d pulses=%0d done_cycle=%0d",
             n, d, abort_at, poke, rises, c);
  endtask

  initial begin
    int toggles, n, ab;
    bus.start = 1'b0; bus.dir_in = 1'b0; bus.steps = '0; bus.abort = 1'b0;

    // Reset then idle with no start.
    repeat (5) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_step", bus.step_out, 0);
    rst = 1'b0;
    toggles = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.step_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) toggles++;
    end
    chk("idle_quiet", toggles, 0);
    chk("idle_dir", bus.dir, 0);
    chk("idle_left", bus.steps_left, 0);
    $display("reset/idle check done");

    // Abort while idle must not leak into the next move.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;

    run_move(10, 1'b1, 0, 1'b0);
    run_move(3, 1'b0, 0, 1'b0);
    run_move(0, 1'b1, 0, 1'b0);
    run_move(1000, 1'b1, 2, 1'b0);
    run_move(5, 1'b0, 0, 1'b1);
    run_move(6, 1'b1, 1, 1'b0);

    // Reset in the middle of a step.
    @(negedge clk);
    bus.start = 1'b1; bus.steps = 50; bus.dir_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && bus.step_out !== 1'b1; i++) @(negedge clk);
    chk("reach_high", bus.step_out, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_step", bus.step_out, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_dir", bus.dir, 0);
    chk("mid_rst_left", bus.steps_left, 0);
    rst = 1'b0;
    pos_model = 0;
    $display("mid-move reset done");

    run_move(10, 1'b1, 0, 1'b0);
    run_move(3, 1'b0, 0, 1'b0);
`ifdef STEP_POS_TRACK_EN
    chk("pos_plus10_minus3", bus.pos, 7);
`endif

    repeat (20) begin
      n  = $urandom_range(0, 30);
      ab = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      run_move(n, 1'($urandom), ab, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
